// File: rtl/matrix_mult_pkg.sv
// Shared types and default geometry for the matrix-multiply array front end.
// Default-derived beat counts are exported so neighbouring blocks agree on tile framing.
package matrix_mult_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LEAD,
      STREAM,
      DRAIN
   } feeder_state_t;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   localparam int DEF_ARRAY_HEIGHT = 4;
   localparam int DEF_ARRAY_WIDTH  = 32;
   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_BUS_WIDTH    = 256;
   localparam int DEF_MAX_N        = 64;

   localparam int ELEMS_PER_BEAT = DEF_BUS_WIDTH / DEF_DATA_WIDTH;
   localparam int A_BEATS        = ceil_div(DEF_ARRAY_HEIGHT, ELEMS_PER_BEAT);
   localparam int B_BEATS        = DEF_ARRAY_WIDTH / ELEMS_PER_BEAT;
   localparam int BEATS_PER_STEP = A_BEATS + B_BEATS;
   localparam int LEAD_CYCLES    = 2;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register that skews one array edge lane by DEPTH cycles.
// DEPTH=0 degenerates to a straight wire.
module skew_delay_line #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_reset;
      assign unused_clk_reset = &{1'b0, clk, reset};
      assign q = d;
   end else begin : g_shift
      logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

      always_ff @(posedge clk) begin
         if (reset) begin
            sr <= '0;
         end else begin
            sr[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
               sr[s] <= sr[s-1];
            end
         end
      end

      assign q = sr[DEPTH-1];
   end

endmodule

// File: rtl/array_operand_feeder.sv
// Loads one operand tile from the inbound bus, then replays it into the systolic
// array edges with diagonal skew and issues the array_start launch pulse.
module array_operand_feeder
   import matrix_mult_pkg::*;
#(
   parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
   parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
   parameter int MAX_N        = DEF_MAX_N
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [15:0]                            n,
   input  logic                                   start,
   input  logic [BUS_WIDTH-1:0]                   data_i,
   input  logic                                   valid_i,
   output logic                                   ready_o,
   output logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0] array_a_o,
   output logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]  array_b_o,
   output logic                                   array_start,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   err_o
);

   localparam int ELEMS        = BUS_WIDTH / DATA_WIDTH;
   localparam int NUM_A_BEATS  = ceil_div(ARRAY_HEIGHT, ELEMS);
   localparam int NUM_B_BEATS  = ARRAY_WIDTH / ELEMS;
   localparam int STEP_BEATS   = NUM_A_BEATS + NUM_B_BEATS;
   localparam int SKEW_MAX     = (ARRAY_HEIGHT > ARRAY_WIDTH) ? ARRAY_HEIGHT : ARRAY_WIDTH;
   localparam int DRAIN_CYCLES = (SKEW_MAX > 1) ? SKEW_MAX - 1 : 1;
   localparam int PHASE_MAX    = (DRAIN_CYCLES > LEAD_CYCLES) ? DRAIN_CYCLES : LEAD_CYCLES;
   localparam int STEP_W       = $clog2(MAX_N + 1);
   localparam int BEAT_W       = $clog2(STEP_BEATS + 1);
   localparam int PHASE_W      = $clog2(PHASE_MAX + 1);
   localparam int IDX_W        = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   feeder_state_t state, state_nxt;

   logic [STEP_W-1:0]  n_q;
   logic [STEP_W-1:0]  step_cnt;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [PHASE_W-1:0] phase_cnt;
   logic               err_q;

   logic               n_ok;
   logic               accept;
   logic               last_step;
   logic               last_beat;
   logic               lead_end;
   logic               drain_end;
   logic [IDX_W-1:0]   step_idx;

   logic [DATA_WIDTH-1:0] tile_a [MAX_N][ARRAY_HEIGHT];
   logic [DATA_WIDTH-1:0] tile_b [MAX_N][ARRAY_WIDTH];

   logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0] feed_a;
   logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]  feed_b;

   assign n_ok      = (n != '0) && (n <= 16'(MAX_N));
   assign accept    = valid_i && (state == LOAD);
   assign last_step = (step_cnt == n_q - STEP_W'(1));
   assign last_beat = (beat_cnt == BEAT_W'(STEP_BEATS - 1));
   assign lead_end  = (phase_cnt == PHASE_W'(LEAD_CYCLES - 1));
   assign drain_end = (phase_cnt == PHASE_W'(DRAIN_CYCLES - 1));
   assign step_idx  = step_cnt[IDX_W-1:0];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start && n_ok)          state_nxt = LOAD;
         LOAD:    if (accept && last_beat && last_step) state_nxt = LEAD;
         LEAD:    if (lead_end)               state_nxt = STREAM;
         STREAM:  if (last_step)              state_nxt = DRAIN;
         DRAIN:   if (drain_end)              state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_o     = (state == LOAD);
      busy_o      = (state != IDLE);
      array_start = (state == LEAD) && (phase_cnt == '0);
      done_o      = (state == DRAIN) && drain_end;
      err_o       = err_q;
   end

   // Step counter is shared: tile row being written in LOAD, row being replayed in STREAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q       <= '0;
         step_cnt  <= '0;
         beat_cnt  <= '0;
         phase_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= (state == IDLE) && start && !n_ok;
         unique case (state)
            IDLE: begin
               step_cnt  <= '0;
               beat_cnt  <= '0;
               phase_cnt <= '0;
               if (start && n_ok) n_q <= n[STEP_W-1:0];
            end
            LOAD: begin
               if (accept) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     step_cnt <= last_step ? '0 : step_cnt + 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            LEAD:    phase_cnt <= lead_end ? '0 : phase_cnt + 1'b1;
            STREAM:  step_cnt  <= last_step ? '0 : step_cnt + 1'b1;
            DRAIN:   phase_cnt <= phase_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the tile buffer has no reset; stale contents never reach the lanes
   // because the feed is gated to STREAM, which only follows a full reload.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < ARRAY_HEIGHT; i++) begin
            if (int'(beat_cnt) == i / ELEMS)
               tile_a[step_idx][i] <= data_i[(i % ELEMS)*DATA_WIDTH +: DATA_WIDTH];
         end
         for (int j = 0; j < ARRAY_WIDTH; j++) begin
            if (int'(beat_cnt) == NUM_A_BEATS + j / ELEMS)
               tile_b[step_idx][j] <= data_i[(j % ELEMS)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < ARRAY_HEIGHT; i++)
         feed_a[i] = (state == STREAM) ? tile_a[step_idx][i] : '0;
      for (int j = 0; j < ARRAY_WIDTH; j++)
         feed_b[j] = (state == STREAM) ? tile_b[step_idx][j] : '0;
   end

   for (genvar gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_row_skew
      skew_delay_line #(
         .DEPTH      (gi),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_skew (
         .clk   (clk),
         .reset (reset),
         .d     (feed_a[gi]),
         .q     (array_a_o[gi])
      );
   end

   for (genvar gj = 0; gj < ARRAY_WIDTH; gj++) begin : g_col_skew
      skew_delay_line #(
         .DEPTH      (gj),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_skew (
         .clk   (clk),
         .reset (reset),
         .d     (feed_b[gj]),
         .q     (array_b_o[gj])
      );
   end

endmodule

// File: tb/tb_array_operand_feeder.sv
// Randomized bench for array_operand_feeder: expected lanes come from the skew rule
// out[t] = operand[t - T - 2 - lane] applied to the tile the bench itself generated.
module tb_array_operand_feeder;

   localparam int H       = 4;
   localparam int W       = 32;
   localparam int DW      = 16;
   localparam int BUS     = 256;
   localparam int MAXN    = 64;
   localparam int E       = BUS / DW;
   localparam int A_BEATS = (H + E - 1) / E;
   localparam int B_BEATS = W / E;
   localparam int DRAIN   = ((H > W) ? H : W) - 1;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [15:0]            n_in;
   logic                   start;
   logic [BUS-1:0]         data_i;
   logic                   valid_i;
   logic                   ready_o;
   logic [H-1:0][DW-1:0]   array_a_o;
   logic [W-1:0][DW-1:0]   array_b_o;
   logic                   array_start;
   logic                   busy_o;
   logic                   done_o;
   logic                   err_o;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] a_mem [MAXN][H];
   logic [DW-1:0] b_mem [MAXN][W];

   always #5 clk = ~clk;

   array_operand_feeder dut (
      .clk         (clk),
      .reset       (reset),
      .n           (n_in),
      .start       (start),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .array_a_o   (array_a_o),
      .array_b_o   (array_b_o),
      .array_start (array_start),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_quiet_lanes(input string tag);
      check({tag, "_a"}, array_a_o, '0);
      check({tag, "_b"}, array_b_o, '0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after done_o.
   task automatic run_tile(input int nn, input int mode, input bit fixed, input bit poke,
                           input int abort_at);
      logic [BUS-1:0]       beats[$];
      logic [BUS-1:0]       bt;
      logic [H-1:0][DW-1:0] ea;
      logic [W-1:0][DW-1:0] eb;
      int                   idx, cyc, s;
      bit                   v, tog;

      for (int k = 0; k < nn; k++) begin
         for (int i = 0; i < H; i++) a_mem[k][i] = fixed ? DW'(k*1000 + i + 1)   : DW'($urandom);
         for (int j = 0; j < W; j++) b_mem[k][j] = fixed ? DW'(k*1000 + j + 101) : DW'($urandom);
         for (int ab = 0; ab < A_BEATS; ab++) begin
            for (int w = 0; w < BUS/32; w++) bt[w*32 +: 32] = $urandom;
            for (int e = 0; e < E; e++)
               if (ab*E + e < H) bt[e*DW +: DW] = a_mem[k][ab*E + e];
            beats.push_back(bt);
         end
         for (int bb = 0; bb < B_BEATS; bb++) begin
            for (int e = 0; e < E; e++) bt[e*DW +: DW] = b_mem[k][bb*E + e];
            beats.push_back(bt);
         end
      end

      check("idle_busy", busy_o, 1'b0);
      check("idle_ready", ready_o, 1'b0);
      check_quiet_lanes("idle_lanes");
      start = 1'b1;
      n_in  = 16'(nn);
      @(negedge clk);
      start = 1'b0;
      n_in  = 16'($urandom);

      idx = 0;
      cyc = 0;
      tog = 1'b1;
      while (idx < beats.size()) begin
         check("load_ready", ready_o, 1'b1);
         check("load_busy", busy_o, 1'b1);
         check("load_pulses", {array_start, done_o, err_o}, 3'b000);
         check_quiet_lanes("load_lanes");
         if (abort_at >= 0 && idx == abort_at) begin
            reset   = 1'b1;
            valid_i = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check("rst_busy", busy_o, 1'b0);
            check("rst_ready", ready_o, 1'b0);
            check_quiet_lanes("rst_lanes");
            return;
         end
         case (mode)
            0:       v = 1'b1;
            1:       begin v = tog; tog = !tog; end
            default: v = (cyc > 3*beats.size()) ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
         valid_i = v;
         data_i  = v ? beats[idx] : {8{32'hdead_beef}};
         @(negedge clk);
         if (v) idx++;
         cyc++;
      end
      valid_i = 1'b0;

      // t is measured from the expected launch cycle T (first cycle after the last beat).
      for (int t = 0; t <= nn + DRAIN + 1; t++) begin
         for (int i = 0; i < H; i++) begin
            s = t - 2 - i;
            ea[i] = (s >= 0 && s < nn) ? a_mem[s][i] : '0;
         end
         for (int j = 0; j < W; j++) begin
            s = t - 2 - j;
            eb[j] = (s >= 0 && s < nn) ? b_mem[s][j] : '0;
         end
         check("lanes_a", array_a_o, ea);
         check("lanes_b", array_b_o, eb);
         check("launch", array_start, t == 0);
         check("done", done_o, t == nn + DRAIN + 1);
         check("run_busy", busy_o, 1'b1);
         check("run_ready", ready_o, 1'b0);
         check("run_err", err_o, 1'b0);
         start = poke && (t == 3);
         n_in  = 16'd5;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic bad_start(input int nn);
      start = 1'b1;
      n_in  = 16'(nn);
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", err_o, 1'b1);
      check("err_busy", busy_o, 1'b0);
      check("err_ready", ready_o, 1'b0);
      @(negedge clk);
      check("err_clear", err_o, 1'b0);
      check("err_busy2", busy_o, 1'b0);
      check("err_ready2", ready_o, 1'b0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      n_in    = '0;
      valid_i = 1'b0;
      data_i  = '0;
      repeat (3) @(negedge clk);
      check("rst_state", {ready_o, array_start, busy_o, done_o, err_o}, 5'b0);
      check_quiet_lanes("rst_out");
      reset = 1'b0;

      run_tile(1, 0, 1'b1, 1'b0, -1);
      @(negedge clk);
      bad_start(0);
      bad_start(65);
      run_tile(4, 1, 1'b0, 1'b0, -1);
      run_tile(3, 0, 1'b0, 1'b1, -1);
      @(negedge clk);
      run_tile(4, 0, 1'b0, 1'b0, 5);
      run_tile(2, 0, 1'b0, 1'b0, -1);
      // back-to-back: each tile starts on the cycle right after the previous done_o
      run_tile(3, 2, 1'b0, 1'b0, -1);
      run_tile(5, 0, 1'b0, 1'b0, -1);
      for (int r = 0; r < 6; r++) begin
         run_tile($urandom_range(1, 8), $urandom_range(0, 2), 1'b0, 1'b0, -1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      run_tile(MAXN, 2, 1'b0, 1'b0, -1);
      bad_start(MAXN + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
